// File: rtl/prog_timer.sv
// Programmable tick timer: prescaled tick, up/down count, terminal limit,
// one-shot or auto-reload operation, and pause.
module prog_timer #(
  parameter int TIMER_WIDTH = 16,
  parameter int CLK_FREQ    = 36_000_000,
  parameter int TICK_HZ     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [TIMER_WIDTH-1:0] i_load_value,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_mode_down,
  input  logic                   i_auto_reload,
  input  logic [TIMER_WIDTH-1:0] i_limit,
  output logic [TIMER_WIDTH-1:0] o_current_time,
  output logic                   o_tick,
  output logic                   o_expired,
  output logic                   o_running,
  output logic                   o_done
);

  localparam int PRESCALE = (TICK_HZ > 0) ? CLK_FREQ / TICK_HZ : 0;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PS_LAST  = PRESCALE - 1;
  localparam logic [PW-1:0] PS_LAST_V = PS_LAST[PW-1:0];

  generate
    if (TICK_HZ < 1 || PRESCALE < 1 || (CLK_FREQ % TICK_HZ) != 0) begin : g_bad_prescale
      $error("prog_timer: CLK_FREQ/TICK_HZ must be an integer >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [TIMER_WIDTH-1:0] count_reg, count_next;
  logic [PW-1:0]          pre_reg, pre_next;
  logic                   down_reg, down_next;
  logic                   auto_reg, auto_next;
  logic [TIMER_WIDTH-1:0] limit_reg, limit_next;
  logic                   pend_reg, pend_next;   // next tick reloads instead of stepping
  logic                   tick_reg, tick_next;
  logic                   exp_reg, exp_next;

  logic [TIMER_WIDTH-1:0] start_base;
  logic [TIMER_WIDTH-1:0] start_term;
  logic [TIMER_WIDTH-1:0] step_val;
  logic [TIMER_WIDTH-1:0] run_term;
  logic [TIMER_WIDTH-1:0] reload_val;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      pre_reg   <= '0;
      down_reg  <= 1'b0;
      auto_reg  <= 1'b0;
      limit_reg <= '0;
      pend_reg  <= 1'b0;
      tick_reg  <= 1'b0;
      exp_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      pre_reg   <= pre_next;
      down_reg  <= down_next;
      auto_reg  <= auto_next;
      limit_reg <= limit_next;
      pend_reg  <= pend_next;
      tick_reg  <= tick_next;
      exp_reg   <= exp_next;
    end
  end

  // Next-state logic: load beats start, start beats pause, pause beats ticking.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pre_next   = pre_reg;
    down_next  = down_reg;
    auto_next  = auto_reg;
    limit_next = limit_reg;
    pend_next  = pend_reg;
    tick_next  = 1'b0;
    exp_next   = 1'b0;

    // A restart from DONE reloads the count; from IDLE the loaded count is kept.
    if (state_reg == DONE) start_base = i_mode_down ? i_limit : '0;
    else                   start_base = count_reg;
    start_term = i_mode_down ? '0 : i_limit;
    step_val   = down_reg ? count_reg - 1'b1 : count_reg + 1'b1;
    run_term   = down_reg ? '0 : limit_reg;
    reload_val = down_reg ? limit_reg : '0;

    if (i_load) begin
      count_next = i_load_value;
      pre_next   = '0;
      state_next = IDLE;
      pend_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (i_start) begin
            count_next = start_base;
            pre_next   = '0;
            down_next  = i_mode_down;
            auto_next  = i_auto_reload;
            limit_next = i_limit;
            pend_next  = 1'b0;
            state_next = RUN;
            if (start_base == start_term) begin
              exp_next = 1'b1;
              if (i_auto_reload) pend_next = 1'b1;
              else               state_next = DONE;
            end
          end
        end
        default: begin
          // A cycle with pause low counts, including the cycle that leaves PAUSED.
          if (i_pause) begin
            state_next = PAUSED;
          end else begin
            state_next = RUN;
            if (pre_reg == PS_LAST_V) begin
              pre_next  = '0;
              tick_next = 1'b1;
              if (pend_reg) begin
                count_next = reload_val;
                pend_next  = 1'b0;
              end else begin
                count_next = step_val;
                if (step_val == run_term) begin
                  exp_next = 1'b1;
                  if (auto_reg) pend_next = 1'b1;
                  else          state_next = DONE;
                end
              end
            end else begin
              pre_next = pre_reg + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_current_time = count_reg;
  assign o_tick         = tick_reg;
  assign o_expired      = exp_reg;
  assign o_running      = (state_reg == RUN);
  assign o_done         = (state_reg == DONE);

endmodule
